alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Multi-cycle control sequencer that sits directly upstream of the ALU.
- Steps one register-register logic instruction through fetch and execute T-states.
- Asserts the datapath strobes: PC/MAR/MDR/IR/Y/Z enables, register-file select and in/out, and exactly one of the ALU's AND/OR/NEG select lines.
- Handles the memory-read wait during fetch, rejects non-logic opcodes, and reports busy/done/fault.

Parameters:
- OP_AND, 5'b00101, IR[31:27] encoding for and Ra,Rb,Rc
- OP_OR, 5'b00110, IR[31:27] encoding for or Ra,Rb,Rc
- OP_NEG, 5'b10001, IR[31:27] encoding for neg Ra,Rb
- MEM_TIMEOUT, 8, max T1 cycles waiting on mem_ready before fault (>=1)

Ports:
- clock  in  1  system clock, rising-edge
- clear  in  1  asynchronous active-low reset
- start  in  1  begin one instruction; sampled only in IDLE
- ir_opcode  in  5  IR[31:27]; valid from the cycle after ir_in is asserted
- mem_ready  in  1  memory read data valid on MDR input this cycle
- pc_out, mar_in, inc_pc, pc_in  out  1 each  PC/MAR strobes
- read, mdr_in, mdr_out, ir_in  out  1 each  memory/IR strobes
- gra, grb, grc, r_out, r_in  out  1 each  register-file select/enable
- y_in, z_in, zlo_out  out  1 each  Y and Z register strobes
- and_op, or_op, neg_op  out  1 each  ALU operation selects, at most one high
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on successful completion
- fault  out  1  one-cycle pulse on illegal opcode or memory timeout

Behaviour:
- Reset:
  - clear low forces state IDLE asynchronously, regardless of current state (mid-instruction included).
  - All outputs are 0 during and after reset.
  - The wait counter and latched opcode clear to 0.
  - No partial strobes are emitted on reset release.
- Output decoding:
  - All strobes are Moore outputs decoded from the state register plus the latched opcode.
  - Strobes are glitch-free relative to the clock and change only after a rising edge.
- States and asserted outputs:
  - IDLE: nothing asserted. start=1 -> T0; otherwise stay.
  - T0: pc_out, mar_in, inc_pc, z_in. -> T1.
  - T1: zlo_out, pc_in, read, mdr_in.
    - zlo_out and pc_in only in the first T1 cycle, so the PC increments exactly once.
    - read and mdr_in are held every T1 cycle.
    - mem_ready=1 -> T2.
    - Otherwise the wait counter increments; if the counter reaches MEM_TIMEOUT with mem_ready still 0 -> FAULT.
    - mem_ready in the same cycle the counter hits the limit counts as success (-> T2).
  - T2: mdr_out, ir_in. -> T3.
  - T3: latch ir_opcode, decode it combinationally this cycle, then branch:
    - AND/OR: grb, r_out, y_in -> T4.
    - NEG: grb, r_out, neg_op, z_in -> T5 (T4 is skipped; single operand).
    - Any other opcode: no strobes -> FAULT. Ra is never written.
  - T4: grc, r_out, z_in, plus and_op or or_op per the latched opcode. -> T5.
  - T5: zlo_out, gra, r_in. -> DONE.
  - DONE: done=1. -> IDLE.
  - FAULT: fault=1. -> IDLE.
- Opcode handling:
  - The latched opcode holds from T3 until the next T3.
  - The ALU select lines are asserted only in the single cycle whose z_in captures that result.
- Start handling:
  - start while busy=1 is ignored, never queued.
  - start held high continuously restarts at T0 the cycle after DONE/FAULT returns to IDLE, so there is one idle cycle between instructions.
- Latency (no wait states):
  - AND/OR: 7 cycles from the start edge to the done pulse (T0..T5, DONE).
  - NEG: 6 cycles.
  - Each T1 wait cycle adds 1.
- Invariants:
  - done and fault are never high together.
  - and_op, or_op and neg_op are one-hot or all zero.
  - r_in implies gra.
  - r_out implies exactly one of grb/grc.

Test Plan:
- Reset mid-op: start, drive clear=0 asynchronously during T4 -> all outputs 0 immediately, busy=0; after release, the next start begins cleanly at T0.
- AND, no wait: start=1, mem_ready=1 in T1, ir_opcode=5'b00101 -> strobe sequence T0..T5 exactly as specified, and_op high only in T4 with z_in, done pulses 7 cycles after start, r_in with gra in T5.
- NEG path: ir_opcode=5'b10001 -> T4 skipped, neg_op with z_in in T3, y_in never asserted, done 6 cycles after start.
- Memory wait: OR with mem_ready delayed 3 cycles -> read and mdr_in held 4 T1 cycles, pc_in only in the first, done 10 cycles after start; repeat with mem_ready never asserted, MEM_TIMEOUT=8 -> fault after 8 T1 cycles, no ir_in, no r_in.
- Illegal opcode: ir_opcode=5'b00011 -> T3 asserts nothing, fault pulses for 1 cycle, r_in never high, then IDLE.
- Start while busy: pulse start during T2 and T5 -> ignored, single done; start held high -> back-to-back instructions separated by exactly one IDLE cycle.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// ============================================================================
// Module   : alu_op_sequencer
// Purpose  : T-state control sequencer for register-register logic ops
//            (AND/OR/NEG) feeding the ALU datapath strobes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_sequencer #(
    parameter logic [4:0] OP_AND      = 5'b00101,
    parameter logic [4:0] OP_OR       = 5'b00110,
    parameter logic [4:0] OP_NEG      = 5'b10001,
    parameter int         MEM_TIMEOUT = 8
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       start,
    input  logic [4:0] ir_opcode,
    input  logic       mem_ready,
    output logic       pc_out,
    output logic       mar_in,
    output logic       inc_pc,
    output logic       pc_in,
    output logic       read,
    output logic       mdr_in,
    output logic       mdr_out,
    output logic       ir_in,
    output logic       gra,
    output logic       grb,
    output logic       grc,
    output logic       r_out,
    output logic       r_in,
    output logic       y_in,
    output logic       z_in,
    output logic       zlo_out,
    output logic       and_op,
    output logic       or_op,
    output logic       neg_op,
    output logic       busy,
    output logic       done,
    output logic       fault
);

    localparam int                CNT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  C_LIMIT = CNT_W'(MEM_TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_DONE  = 4'd7,
        S_FAULT = 4'd8
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [4:0]       r_opcode;
    logic [4:0]       w_opcode;
    logic             w_is_and;
    logic             w_is_or;
    logic             w_is_neg;

    // In T3 the opcode is decoded straight from IR; afterwards from the latch.
    assign w_opcode  = (r_state == S_T3) ? ir_opcode : r_opcode;
    assign w_is_and  = (w_opcode == OP_AND);
    assign w_is_or   = (w_opcode == OP_OR);
    assign w_is_neg  = (w_opcode == OP_NEG);
    assign w_cnt_inc = r_wait_cnt + CNT_W'(1);

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_opcode   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_T0) begin
                r_wait_cnt <= '0;
            end else if (r_state == S_T1 && !mem_ready) begin
                r_wait_cnt <= w_cnt_inc;
            end
            if (r_state == S_T3) begin
                r_opcode <= ir_opcode;
            end
        end
    end

    always_comb begin
        w_next  = r_state;
        pc_out  = 1'b0;
        mar_in  = 1'b0;
        inc_pc  = 1'b0;
        pc_in   = 1'b0;
        read    = 1'b0;
        mdr_in  = 1'b0;
        mdr_out = 1'b0;
        ir_in   = 1'b0;
        gra     = 1'b0;
        grb     = 1'b0;
        grc     = 1'b0;
        r_out   = 1'b0;
        r_in    = 1'b0;
        y_in    = 1'b0;
        z_in    = 1'b0;
        zlo_out = 1'b0;
        and_op  = 1'b0;
        or_op   = 1'b0;
        neg_op  = 1'b0;
        busy    = (r_state != S_IDLE);
        done    = 1'b0;
        fault   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_T0;
                end
            end
            S_T0: begin
                pc_out = 1'b1;
                mar_in = 1'b1;
                inc_pc = 1'b1;
                z_in   = 1'b1;
                w_next = S_T1;
            end
            S_T1: begin
                // PC writeback only on the first wait cycle so it advances once.
                zlo_out = (r_wait_cnt == '0);
                pc_in   = (r_wait_cnt == '0);
                read    = 1'b1;
                mdr_in  = 1'b1;
                if (mem_ready) begin
                    w_next = S_T2;
                end else if (w_cnt_inc == C_LIMIT) begin
                    w_next = S_FAULT;
                end
            end
            S_T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
                w_next  = S_T3;
            end
            S_T3: begin
                if (w_is_and || w_is_or) begin
                    grb    = 1'b1;
                    r_out  = 1'b1;
                    y_in   = 1'b1;
                    w_next = S_T4;
                end else if (w_is_neg) begin
                    grb    = 1'b1;
                    r_out  = 1'b1;
                    neg_op = 1'b1;
                    z_in   = 1'b1;
                    w_next = S_T5;
                end else begin
                    w_next = S_FAULT;
                end
            end
            S_T4: begin
                grc    = 1'b1;
                r_out  = 1'b1;
                z_in   = 1'b1;
                and_op = w_is_and;
                or_op  = w_is_or;
                w_next = S_T5;
            end
            S_T5: begin
                zlo_out = 1'b1;
                gra     = 1'b1;
                r_in    = 1'b1;
                w_next  = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            S_FAULT: begin
                fault  = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
// Module   : tb_alu_op_sequencer
// Purpose  : Table-driven scoreboard bench for alu_op_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_op_sequencer;

    localparam int C_MEM_TIMEOUT = 8;

    localparam logic [21:0] M_PC_OUT  = 22'd1 << 21;
    localparam logic [21:0] M_MAR_IN  = 22'd1 << 20;
    localparam logic [21:0] M_INC_PC  = 22'd1 << 19;
    localparam logic [21:0] M_PC_IN   = 22'd1 << 18;
    localparam logic [21:0] M_READ    = 22'd1 << 17;
    localparam logic [21:0] M_MDR_IN  = 22'd1 << 16;
    localparam logic [21:0] M_MDR_OUT = 22'd1 << 15;
    localparam logic [21:0] M_IR_IN   = 22'd1 << 14;
    localparam logic [21:0] M_GRA     = 22'd1 << 13;
    localparam logic [21:0] M_GRB     = 22'd1 << 12;
    localparam logic [21:0] M_GRC     = 22'd1 << 11;
    localparam logic [21:0] M_R_OUT   = 22'd1 << 10;
    localparam logic [21:0] M_R_IN    = 22'd1 << 9;
    localparam logic [21:0] M_Y_IN    = 22'd1 << 8;
    localparam logic [21:0] M_Z_IN    = 22'd1 << 7;
    localparam logic [21:0] M_ZLO_OUT = 22'd1 << 6;
    localparam logic [21:0] M_AND     = 22'd1 << 5;
    localparam logic [21:0] M_OR      = 22'd1 << 4;
    localparam logic [21:0] M_NEG     = 22'd1 << 3;
    localparam logic [21:0] M_BUSY    = 22'd1 << 2;
    localparam logic [21:0] M_DONE    = 22'd1 << 1;
    localparam logic [21:0] M_FAULT   = 22'd1 << 0;

    logic       clock;
    logic       clear;
    logic       start;
    logic [4:0] ir_opcode;
    logic       mem_ready;
    logic pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in;
    logic gra, grb, grc, r_out, r_in, y_in, z_in, zlo_out;
    logic and_op, or_op, neg_op, busy, done, fault;
    logic [21:0] w_obs;

    int n_checks = 0;
    int n_errors = 0;
    logic [21:0] exp_q[$];

    typedef struct {
        string      name;
        logic [4:0] op;
        int         delay;     // T1 wait cycles before mem_ready; -1 = never
        int         reps;      // instructions run back to back with start held
        int         pokes;     // bit c set: pulse start in cycle c
        int         exp_end;   // cycle of the final done/fault pulse
        bit         exp_fault;
    } vec_t;

    vec_t vecs[10];

    alu_op_sequencer #(
        .OP_AND      (5'b00101),
        .OP_OR       (5'b00110),
        .OP_NEG      (5'b10001),
        .MEM_TIMEOUT (C_MEM_TIMEOUT)
    ) u_dut (
        .clock     (clock),
        .clear     (clear),
        .start     (start),
        .ir_opcode (ir_opcode),
        .mem_ready (mem_ready),
        .pc_out    (pc_out),
        .mar_in    (mar_in),
        .inc_pc    (inc_pc),
        .pc_in     (pc_in),
        .read      (read),
        .mdr_in    (mdr_in),
        .mdr_out   (mdr_out),
        .ir_in     (ir_in),
        .gra       (gra),
        .grb       (grb),
        .grc       (grc),
        .r_out     (r_out),
        .r_in      (r_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .zlo_out   (zlo_out),
        .and_op    (and_op),
        .or_op     (or_op),
        .neg_op    (neg_op),
        .busy      (busy),
        .done      (done),
        .fault     (fault)
    );

    assign w_obs = {pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in,
                    gra, grb, grc, r_out, r_in, y_in, z_in, zlo_out,
                    and_op, or_op, neg_op, busy, done, fault};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int cyc, input logic [21:0] got,
                         input logic [21:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %06h expected %06h", name, cyc, got, expv);
        end
    endtask

    task automatic check_int(input string name, input int got, input int expv);
        n_checks++;
        if (got != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    // Reference strobe trace for one instruction, ending with one IDLE cycle.
    task automatic push_trace(input logic [4:0] op, input int delay);
        bit timeout;
        int t1n;
        timeout = (delay < 0) || (delay >= C_MEM_TIMEOUT);
        t1n     = timeout ? C_MEM_TIMEOUT : delay + 1;
        exp_q.push_back(M_PC_OUT | M_MAR_IN | M_INC_PC | M_Z_IN | M_BUSY);
        for (int i = 0; i < t1n; i++) begin
            exp_q.push_back((i == 0 ? (M_ZLO_OUT | M_PC_IN) : 22'd0) | M_READ | M_MDR_IN | M_BUSY);
        end
        if (timeout) begin
            exp_q.push_back(M_FAULT | M_BUSY);
            exp_q.push_back(22'd0);
            return;
        end
        exp_q.push_back(M_MDR_OUT | M_IR_IN | M_BUSY);
        if (op == 5'b00101 || op == 5'b00110) begin
            exp_q.push_back(M_GRB | M_R_OUT | M_Y_IN | M_BUSY);
            exp_q.push_back(M_GRC | M_R_OUT | M_Z_IN | M_BUSY |
                            (op == 5'b00101 ? M_AND : M_OR));
        end else if (op == 5'b10001) begin
            exp_q.push_back(M_GRB | M_R_OUT | M_NEG | M_Z_IN | M_BUSY);
        end else begin
            exp_q.push_back(M_BUSY);
            exp_q.push_back(M_FAULT | M_BUSY);
            exp_q.push_back(22'd0);
            return;
        end
        exp_q.push_back(M_ZLO_OUT | M_GRA | M_R_IN | M_BUSY);
        exp_q.push_back(M_DONE | M_BUSY);
        exp_q.push_back(22'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int          c;
        int          n_end;
        int          last_end;
        bit          last_fault;
        logic [21:0] e;
        exp_q.delete();
        for (int r = 0; r < v.reps; r++) begin
            push_trace(v.op, v.delay);
        end
        @(negedge clock);
        start      = 1'b1;
        ir_opcode  = v.op;
        mem_ready  = 1'b0;
        c          = 0;
        n_end      = 0;
        last_end   = 0;
        last_fault = 1'b0;
        while (exp_q.size() > 0 && c < 200) begin
            @(negedge clock);
            c++;
            e = exp_q.pop_front();
            check(v.name, c, w_obs, e);
            if (done || fault) begin
                n_end++;
                last_end   = c;
                last_fault = fault;
            end
            start     = (c <= 8 * (v.reps - 1)) || (c < 32 && v.pokes[c]);
            mem_ready = (v.delay >= 0) && (c >= 2 + v.delay);
        end
        start     = 1'b0;
        mem_ready = 1'b0;
        check_int({v.name, "_trace_left"}, exp_q.size(), 0);
        check_int({v.name, "_completions"}, n_end, v.reps);
        check_int({v.name, "_end_cycle"}, last_end, v.exp_end);
        check_int({v.name, "_fault_kind"}, int'(last_fault), int'(v.exp_fault));
    endtask

    initial begin
        vecs[0] = '{"and_nowait",   5'b00101,  0, 1, 0,     7, 1'b0};
        vecs[1] = '{"or_nowait",    5'b00110,  0, 1, 0,     7, 1'b0};
        vecs[2] = '{"neg_nowait",   5'b10001,  0, 1, 0,     6, 1'b0};
        vecs[3] = '{"or_wait3",     5'b00110,  3, 1, 0,    10, 1'b0};
        vecs[4] = '{"neg_wait2",    5'b10001,  2, 1, 0,     8, 1'b0};
        vecs[5] = '{"and_wait_lim", 5'b00101,  7, 1, 0,    14, 1'b0};
        vecs[6] = '{"mem_timeout",  5'b00110, -1, 1, 0,    10, 1'b1};
        vecs[7] = '{"illegal_op",   5'b00011,  0, 1, 0,     5, 1'b1};
        vecs[8] = '{"start_busy",   5'b00101,  0, 1, 32'h48, 7, 1'b0};
        vecs[9] = '{"back_to_back", 5'b00110,  0, 2, 0,    15, 1'b0};

        clear     = 1'b0;
        start     = 1'b0;
        ir_opcode = 5'b00000;
        mem_ready = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_hold", 0, w_obs, 22'd0);
        clear = 1'b1;
        @(negedge clock);
        check("reset_release", 0, w_obs, 22'd0);

        foreach (vecs[i]) begin
            run_vec(vecs[i]);
        end

        // Asynchronous clear in the middle of T4, then a clean restart.
        @(negedge clock);
        start     = 1'b1;
        ir_opcode = 5'b00101;
        mem_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        check("midop_in_t4", 5, w_obs, M_GRC | M_R_OUT | M_Z_IN | M_AND | M_BUSY);
        #2 clear = 1'b0;
        #1 check("midop_async_clear", 5, w_obs, 22'd0);
        @(negedge clock);
        check("midop_held", 6, w_obs, 22'd0);
        clear = 1'b1;
        @(negedge clock);
        check("midop_released", 7, w_obs, 22'd0);
        mem_ready = 1'b0;
        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
